// File: rtl/multi_samp.sv
// multi_samp: unsigned WIDTH x WIDTH multiplier with overflow flag.
// Res[2*WIDTH-1:0] holds the full product, Res[2*WIDTH] is set when the
// product does not fit in WIDTH bits.
// Build option: define MULTI_SAMP_FAST_EN for a single-cycle registered
// multiplier (busy tied low, start accepted every cycle); otherwise a
// shift-add datapath performs one partial-product step per clock.
//
// state | meaning
// IDLE  | waiting for start, Res holds last result
// RUN   | shift-add steps in progress, busy high
module multi_samp #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   A_in,
  input  logic [WIDTH-1:0]   B_in,
  output logic [2*WIDTH:0]   Res,
  output logic               busy,
  output logic               done
);

`ifdef MULTI_SAMP_FAST_EN

  logic [2*WIDTH:0]   res_d, res_q;
  logic               done_d, done_q;
  logic [2*WIDTH-1:0] prod;

  // Combinational product, captured whenever start is high
  always_comb begin
    prod   = {{WIDTH{1'b0}}, A_in} * {{WIDTH{1'b0}}, B_in};
    res_d  = res_q;
    done_d = 1'b0;
    if (start) begin
      res_d  = {|prod[2*WIDTH-1:WIDTH], prod};
      done_d = 1'b1;
    end
  end

  // Result and done registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_q  <= '0;
      done_q <= 1'b0;
    end else begin
      res_q  <= res_d;
      done_q <= done_d;
    end
  end

  assign Res  = res_q;
  assign done = done_q;
  assign busy = 1'b0;

`else

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state_d, state_q;
  logic [2*WIDTH-1:0] mcand_d, mcand_q;
  logic [2*WIDTH-1:0] acc_d, acc_q;
  logic [2*WIDTH-1:0] acc_sum;
  logic [WIDTH-1:0]   mplier_d, mplier_q;
  logic [CW-1:0]      cnt_d, cnt_q;
  logic [2*WIDTH:0]   res_d, res_q;
  logic               done_d, done_q;

  // Next-state and shift-add step; the down-counter's terminal count marks the last step
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    res_d    = res_q;
    done_d   = 1'b0;
    acc_sum  = acc_q + (mplier_q[0] ? mcand_q : '0);
    case (state_q)
      IDLE: begin
        if (start) begin
          mcand_d  = {{WIDTH{1'b0}}, A_in};
          mplier_d = B_in;
          acc_d    = '0;
          cnt_d    = CW'(WIDTH - 1);
          state_d  = RUN;
        end
      end
      RUN: begin
        acc_d    = acc_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          res_d   = {|acc_sum[2*WIDTH-1:WIDTH], acc_sum};
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, operand, accumulator and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      res_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      res_q    <= res_d;
      done_q   <= done_d;
    end
  end

  assign Res  = res_q;
  assign done = done_q;
  assign busy = (state_q == RUN);

`endif

endmodule

// File: tb/tb_multi_samp.sv
// Testbench for multi_samp: directed cases plus randomized traffic, checked
// each cycle against a transaction-level model (product, latency, busy/done).
module tb_multi_samp;
  localparam int W = 4;
`ifdef MULTI_SAMP_FAST_EN
  localparam int LAT = 1;
  localparam bit FAST = 1'b1;
`else
  localparam int LAT = W;
  localparam bit FAST = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start = 1'b0;
  logic [W-1:0]   A_in = '0;
  logic [W-1:0]   B_in = '0;
  logic [2*W:0]   Res;
  logic           busy;
  logic           done;

  int checks = 0;
  int errors = 0;

  // model state
  int m_res   = 0;
  bit m_busy  = 0;
  bit m_done  = 0;
  int m_left  = 0;
  int m_pend  = 0;

  multi_samp #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .A_in(A_in), .B_in(B_in),
    .Res(Res), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int encode(input int a, input int b);
    int p;
    p = a * b;
    return p + ((p > (1 << W) - 1) ? (1 << (2 * W)) : 0);
  endfunction

  task automatic model_reset();
    m_res = 0; m_busy = 0; m_done = 0; m_left = 0; m_pend = 0;
  endtask

  // Advance one clock: update the model with the inputs seen at the edge, then compare
  task automatic step();
    @(posedge clk);
    if (rst) model_reset();
    else begin
      m_done = 0;
      if (FAST) begin
        if (start) begin m_res = encode(int'(A_in), int'(B_in)); m_done = 1; end
      end else if (m_busy) begin
        m_left--;
        if (m_left == 0) begin m_res = m_pend; m_done = 1; m_busy = 0; end
      end else if (start) begin
        m_pend = encode(int'(A_in), int'(B_in));
        m_left = LAT;
        m_busy = 1;
      end
    end
    #1;
    chk("res",  32'(Res),  32'(m_res));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("done", 32'(done), 32'(m_done));
  endtask

  // Pulse start for one edge, then wait (bounded) for done
  task automatic run_op(input int a, input int b);
    bit seen;
    A_in = W'(a); B_in = W'(b); start = 1'b1;
    step();
    start = 1'b0;
    seen = done;
    for (int i = 0; i < 3 * W + 4 && !seen; i++) begin
      step();
      seen = done;
    end
    chk("done_seen", 32'(seen), 32'd1);
  endtask

  task automatic async_reset();
    #3;
    rst = 1'b1;
    model_reset();
    #1;
    chk("rst_res",  32'(Res),  32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
  endtask

  initial begin
    int done_cnt;
    rst = 1'b1;
    #12;
    chk("init_res",  32'(Res),  32'd0);
    chk("init_busy", 32'(busy), 32'd0);
    chk("init_done", 32'(done), 32'd0);
    rst = 1'b0;

    // first edge after reset release accepts start
    run_op(0, 1);
    chk("res_0x1", 32'(Res), 32'h000);
    run_op(15, 1);
    chk("res_15x1", 32'(Res), 32'h00F);
    run_op(15, 15);
    chk("res_15x15", 32'(Res), 32'h1E1);
    run_op(4, 4);
    chk("res_4x4", 32'(Res), 32'h110);
    run_op(3, 5);
    chk("res_3x5", 32'(Res), 32'h00F);

    // start while busy ignored; operands changed after acceptance
    A_in = 4'd6; B_in = 4'd7; start = 1'b1;
    step();
    A_in = 4'd2; step();
    A_in = 4'd9; step();
    start = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 2 * W + 4; i++) begin
      step();
      if (done) done_cnt++;
    end
    chk("ignore_done_cnt", 32'(done_cnt), FAST ? 32'd0 : 32'd1);
    if (!FAST) chk("ignore_res", 32'(Res), 32'(encode(6, 7)));

    // start held high re-launches on the edge after returning to idle
    A_in = 4'd5; B_in = 4'd3; start = 1'b1;
    for (int i = 0; i < 3 * LAT + 4; i++) step();
    start = 1'b0;
    for (int i = 0; i < LAT + 2; i++) step();

    // reset mid-operation: after edge N+2
    async_reset();
    step(); rst = 1'b0;
    A_in = 4'd7; B_in = 4'd9; start = 1'b1;
    step(); start = 1'b0;
    step(); step();
    async_reset();
    done_cnt = 0;
    step(); rst = 1'b0;
    for (int i = 0; i < W + 2; i++) begin
      step();
      if (done) done_cnt++;
    end
    chk("abort_no_done", 32'(done_cnt), 32'd0);
    chk("abort_res", 32'(Res), 32'd0);
    run_op(7, 9);
    chk("after_abort_res", 32'(Res), 32'h13F);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      A_in  = W'($urandom_range((1 << W) - 1));
      B_in  = W'($urandom_range((1 << W) - 1));
      start = ($urandom_range(99) < 40);
      if ($urandom_range(99) < 3) begin
        async_reset();
        step();
        rst = 1'b0;
      end else begin
        step();
      end
    end
    start = 1'b0;
    for (int i = 0; i < LAT + 2; i++) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/multi_samp.md
MULTI_SAMP -- requirements
Module: multi_samp

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the operand width; Res width is 2*WIDTH+1.
REQ-002 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-003 Port clk SHALL be an input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port rst SHALL be an input, 1 bit: asynchronous, active-high reset.
REQ-005 Port start SHALL be an input, 1 bit: request to multiply the present A_in and B_in.
REQ-006 Port A_in SHALL be an input, WIDTH bits: unsigned multiplicand.
REQ-007 Port B_in SHALL be an input, WIDTH bits: unsigned multiplier.
REQ-008 Port Res SHALL be an output, 2*WIDTH+1 bits: Res[2*WIDTH-1:0] is the product and Res[2*WIDTH] is the overflow flag.
REQ-009 Port busy SHALL be an output, 1 bit: high while a multiplication is in progress.
REQ-010 Port done SHALL be an output, 1 bit: one-cycle pulse when Res is updated.

Function
REQ-011 The block SHALL compute the unsigned product A_in*B_in using a shift-add datapath, one partial-product step per clock.
REQ-012 States SHALL be IDLE and RUN.
- IDLE -> RUN on a rising edge with start=1.
- RUN -> IDLE after WIDTH steps.
REQ-013 On accepting start, the block SHALL latch A_in and B_in, clear the accumulator, and set busy=1 from the next cycle.
- Later operand changes have no effect on the current operation.
REQ-014 With start accepted at edge N, Res and done SHALL update at edge N+WIDTH (4 cycles at default) and busy SHALL return to 0 at that same edge.
REQ-015 done SHALL be high for exactly one cycle per completed operation.
REQ-016 Res SHALL hold its last value until the next completion or reset.
REQ-017 start while busy=1 SHALL be ignored: no restart, no queueing.
REQ-018 start held high continuously SHALL begin a new operation on the first edge after returning to IDLE.
REQ-019 Overflow bit Res[2*WIDTH] SHALL be 1 exactly when the product exceeds 2^WIDTH-1 (does not fit in WIDTH bits), else 0.
REQ-020 Res[2*WIDTH-1:0] SHALL always be the full, untruncated product; the product never wraps.

Reset
REQ-021 While rst=1, the block SHALL asynchronously force Res=0, busy=0, done=0, state=IDLE, and clear the accumulator and operand registers.
REQ-022 Reset asserted mid-operation SHALL abort it; no done pulse and no Res update follow.
REQ-023 The first start SHALL be accepted on the first rising edge with rst=0.

Configuration
REQ-024 Macro MULTI_SAMP_FAST_EN SHALL select between two implementations; interface and Res/overflow encoding are identical in both.
- Defined: the product is formed combinationally and registered; Res and done update at edge N+1, busy stays 0, and start is accepted every cycle.
- Undefined: sequential behaviour per REQ-011..REQ-018.

Verification
REQ-025 Reset: assert rst mid-cycle -> Res=0, busy=0, done=0 immediately, before any clock edge.
REQ-026 A_in=0000, B_in=0001, start pulse -> after 4 cycles done=1, Res[7:0]=00000000, Res[8]=0.
REQ-027 A_in=1111, B_in=0001, start pulse -> Res[7:0]=00001111, Res[8]=0.
REQ-028 A_in=1111, B_in=1111 -> Res[7:0]=11100001, Res[8]=1; A_in=0100, B_in=0100 -> Res[7:0]=00010000, Res[8]=1.
REQ-029 Start at edge N, then change A_in and pulse start at N+1 and N+2 -> result uses the original operands, exactly one done pulse, and a new op starts only after busy=0.
REQ-030 Assert rst at edge N+2 of an operation -> no done pulse; Res stays 0; the next start gives the correct product.
